// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpu_pkg
// Description : Shared FPU constants: rounding modes, default widths, fields.
// Revision    : 1.0 - initial release
// ============================================================================
package fpu_pkg;

    localparam logic [1:0] RM_RNE = 2'b00;
    localparam logic [1:0] RM_RTZ = 2'b01;
    localparam logic [1:0] RM_RUP = 2'b10;
    localparam logic [1:0] RM_RDN = 2'b11;

    localparam int EXP_W_DEF  = 8;
    localparam int MANT_W_DEF = 23;

    localparam logic [EXP_W_DEF-1:0] EXP_MAX = '1;

    // Bit offsets inside a packed {sign, exp, frac} word of default width
    localparam int EXP_LSB  = MANT_W_DEF;
    localparam int SIGN_POS = EXP_W_DEF + MANT_W_DEF;

endpackage
`default_nettype wire

// File: rtl/fp_round_decide.sv
`default_nettype none
// ============================================================================
// Module      : fp_round_decide
// Description : Combinational rounding-increment and inexact decision.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_round_decide
    import fpu_pkg::*;
#(
    parameter int EXP_W = EXP_W_DEF
) (
    input  logic             i_sign,
    input  logic             i_lsb,
    input  logic             i_g,
    input  logic             i_r,
    input  logic             i_s,
    input  logic [1:0]       i_rm,
    input  logic [EXP_W-1:0] i_exp,
    output logic             o_inc,
    output logic             o_inexact
);

    logic w_any;
    logic w_special;

    assign w_any     = i_g | i_r | i_s;
    assign w_special = &i_exp;

    always_comb begin
        o_inc     = 1'b0;
        o_inexact = 1'b0;
        // Inf/NaN inputs pass through untouched and never flag
        if (!w_special) begin
            o_inexact = w_any;
            case (i_rm)
                RM_RNE:  o_inc = i_g & (i_r | i_s | i_lsb);
                RM_RTZ:  o_inc = 1'b0;
                RM_RUP:  o_inc = ~i_sign & w_any;
                default: o_inc = i_sign & w_any;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_round_stage.sv
`default_nettype none
// ============================================================================
// Module      : fp_round_stage
// Description : Two-stage IEEE-754 rounding stage with valid/ready flow
//               control, overflow handling and saturating inexact counter.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_round_stage
    import fpu_pkg::*;
#(
    parameter int EXP_W  = EXP_W_DEF,
    parameter int MANT_W = MANT_W_DEF,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sign,
    input  logic [EXP_W-1:0]        in_exp,
    input  logic [MANT_W:0]         in_mant,
    input  logic                    in_g,
    input  logic                    in_r,
    input  logic                    in_s,
    input  logic [1:0]              in_rm,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+MANT_W:0]   out_result,
    output logic                    out_inexact,
    output logic                    out_overflow,
    output logic [CNT_W-1:0]        inexact_cnt,
    input  logic                    cnt_clr
);

    localparam logic [EXP_W-1:0]  c_EXP_ONES  = '1;
    localparam logic [EXP_W-1:0]  c_EXP_MAXF  = c_EXP_ONES - EXP_W'(1);
    localparam logic [MANT_W-1:0] c_FRAC_ONES = '1;

    logic                  r_s1_valid;
    logic                  r_s1_sign;
    logic [EXP_W-1:0]      r_s1_exp;
    logic [MANT_W:0]       r_s1_mant;
    logic                  r_s1_inc;
    logic                  r_s1_inexact;
    logic [1:0]            r_s1_rm;

    logic                  r_s2_valid;
    logic [EXP_W+MANT_W:0] r_out_result;
    logic                  r_out_inexact;
    logic                  r_out_overflow;
    logic [CNT_W-1:0]      r_cnt;

    logic                  w_s1_adv;
    logic                  w_s2_adv;
    logic                  w_inc;
    logic                  w_inexact;
    logic [MANT_W+1:0]     w_sum;
    logic [EXP_W-1:0]      w_res_exp;
    logic [MANT_W-1:0]     w_res_frac;
    logic                  w_ovf;
    logic                  w_res_inexact;

    assign w_s2_adv = out_ready | ~r_s2_valid;
    assign w_s1_adv = w_s2_adv | ~r_s1_valid;
    assign in_ready = w_s1_adv;

    fp_round_decide #(
        .EXP_W     (EXP_W)
    ) u_decide (
        .i_sign    (in_sign),
        .i_lsb     (in_mant[0]),
        .i_g       (in_g),
        .i_r       (in_r),
        .i_s       (in_s),
        .i_rm      (in_rm),
        .i_exp     (in_exp),
        .o_inc     (w_inc),
        .o_inexact (w_inexact)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid   <= 1'b0;
            r_s1_sign    <= 1'b0;
            r_s1_exp     <= '0;
            r_s1_mant    <= '0;
            r_s1_inc     <= 1'b0;
            r_s1_inexact <= 1'b0;
            r_s1_rm      <= RM_RNE;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_sign    <= in_sign;
                r_s1_exp     <= in_exp;
                r_s1_mant    <= in_mant;
                r_s1_inc     <= w_inc;
                r_s1_inexact <= w_inexact;
                r_s1_rm      <= in_rm;
            end
        end
    end

    assign w_sum = {1'b0, r_s1_mant} + (MANT_W+2)'(r_s1_inc);

    always_comb begin
        w_res_exp  = r_s1_exp;
        w_res_frac = w_sum[MANT_W-1:0];
        if (w_sum[MANT_W+1]) begin
            w_res_exp  = r_s1_exp + EXP_W'(1);
            w_res_frac = '0;
        end else if ((r_s1_exp == '0) && w_sum[MANT_W]) begin
            w_res_exp = EXP_W'(1);
        end

        // An all-ones exponent is only an overflow when the input was finite
        w_ovf         = ~(&r_s1_exp) & (&w_res_exp);
        w_res_inexact = r_s1_inexact | w_ovf;

        if (w_ovf) begin
            w_res_exp  = c_EXP_ONES;
            w_res_frac = '0;
            case (r_s1_rm)
                RM_RNE: ;
                RM_RTZ: begin
                    w_res_exp  = c_EXP_MAXF;
                    w_res_frac = c_FRAC_ONES;
                end
                RM_RUP: if (r_s1_sign) begin
                    w_res_exp  = c_EXP_MAXF;
                    w_res_frac = c_FRAC_ONES;
                end
                default: if (!r_s1_sign) begin
                    w_res_exp  = c_EXP_MAXF;
                    w_res_frac = c_FRAC_ONES;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid     <= 1'b0;
            r_out_result   <= '0;
            r_out_inexact  <= 1'b0;
            r_out_overflow <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_result   <= {r_s1_sign, w_res_exp, w_res_frac};
                r_out_inexact  <= w_res_inexact;
                r_out_overflow <= w_ovf;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (cnt_clr) begin
            r_cnt <= '0;
        end else if (r_s2_valid && out_ready && r_out_inexact && !(&r_cnt)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign out_valid    = r_s2_valid;
    assign out_result   = r_out_result;
    assign out_inexact  = r_out_inexact;
    assign out_overflow = r_out_overflow;
    assign inexact_cnt  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fp_round_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_round_stage
// Description : Directed self-checking bench for fp_round_stage (CNT_W=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_round_stage;
    import fpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [7:0]  in_exp = '0;
    logic [23:0] in_mant = '0;
    logic        in_g = 1'b0;
    logic        in_r = 1'b0;
    logic        in_s = 1'b0;
    logic [1:0]  in_rm = RM_RNE;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic        out_inexact;
    logic        out_overflow;
    logic [1:0]  inexact_cnt;
    logic        cnt_clr = 1'b0;

    int n_checks = 0;
    int n_fails  = 0;
    int exp_cnt  = 0;

    fp_round_stage #(
        .EXP_W        (8),
        .MANT_W       (23),
        .CNT_W        (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sign      (in_sign),
        .in_exp       (in_exp),
        .in_mant      (in_mant),
        .in_g         (in_g),
        .in_r         (in_r),
        .in_s         (in_s),
        .in_rm        (in_rm),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_inexact  (out_inexact),
        .out_overflow (out_overflow),
        .inexact_cnt  (inexact_cnt),
        .cnt_clr      (cnt_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic sg, input logic [7:0] e, input logic [23:0] m,
                         input logic [2:0] grs, input logic [1:0] rm);
        in_sign = sg;
        in_exp  = e;
        in_mant = m;
        {in_g, in_r, in_s} = grs;
        in_rm   = rm;
    endtask

    // One beat through an otherwise idle pipe, then its output handshake.
    task automatic beat(input string tag, input logic sg, input logic [7:0] e,
                        input logic [23:0] m, input logic [2:0] grs, input logic [1:0] rm,
                        input logic [31:0] er, input logic ex_inx, input logic ex_ovf,
                        input logic clr);
        @(negedge clk);
        drive(sg, e, m, grs, rm);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check({tag, " valid"},    64'(out_valid),    64'(1'b1));
        check({tag, " result"},   64'(out_result),   64'(er));
        check({tag, " inexact"},  64'(out_inexact),  64'(ex_inx));
        check({tag, " overflow"}, 64'(out_overflow), 64'(ex_ovf));
        cnt_clr = clr;
        @(negedge clk);
        cnt_clr = 1'b0;
        if (clr)
            exp_cnt = 0;
        else if (ex_inx && exp_cnt != 3)
            exp_cnt++;
        check({tag, " drained"}, 64'(out_valid),   64'(1'b0));
        check({tag, " cnt"},     64'(inexact_cnt), 64'(exp_cnt));
    endtask

    logic [31:0] bp_exp [4];
    int sent;
    int got;

    initial begin
        repeat (3) @(negedge clk);
        check("rst out_valid",    64'(out_valid),    64'(1'b0));
        check("rst out_result",   64'(out_result),   64'(32'h0));
        check("rst out_inexact",  64'(out_inexact),  64'(1'b0));
        check("rst out_overflow", 64'(out_overflow), 64'(1'b0));
        check("rst cnt",          64'(inexact_cnt),  64'(2'd0));
        rst_n = 1'b1;
        @(negedge clk);
        check("idle in_ready",    64'(in_ready),     64'(1'b1));

        beat("rne_tie_even", 1'b0, 8'h80, 24'hC00000, 3'b100, RM_RNE, 32'h40400000, 1'b1, 1'b0, 1'b0);
        beat("rne_tie_odd",  1'b0, 8'h80, 24'hC00001, 3'b100, RM_RNE, 32'h40400002, 1'b1, 1'b0, 1'b0);
        beat("carry_renorm", 1'b0, 8'h7F, 24'hFFFFFF, 3'b101, RM_RNE, 32'h40000000, 1'b1, 1'b0, 1'b0);
        beat("ovf_rne",      1'b1, 8'hFE, 24'hFFFFFF, 3'b100, RM_RNE, 32'hFF800000, 1'b1, 1'b1, 1'b0);
        check("ovf_rne sign", 64'(out_result[SIGN_POS]), 64'(1'b1));
        check("ovf_rne exp",  64'(out_result[EXP_LSB +: EXP_W_DEF]), 64'(EXP_MAX));
        beat("ovf_rtz",      1'b1, 8'hFE, 24'hFFFFFF, 3'b100, RM_RTZ, 32'hFF7FFFFF, 1'b1, 1'b0, 1'b0);
        beat("ovf_rup_neg",  1'b1, 8'hFE, 24'hFFFFFF, 3'b100, RM_RUP, 32'hFF7FFFFF, 1'b1, 1'b0, 1'b0);
        beat("ovf_rdn_neg",  1'b1, 8'hFE, 24'hFFFFFF, 3'b100, RM_RDN, 32'hFF800000, 1'b1, 1'b1, 1'b0);
        beat("ovf_rup_pos",  1'b0, 8'hFE, 24'hFFFFFF, 3'b100, RM_RUP, 32'h7F800000, 1'b1, 1'b1, 1'b0);
        beat("subn_promote", 1'b0, 8'h00, 24'h7FFFFF, 3'b100, RM_RNE, 32'h00800000, 1'b1, 1'b0, 1'b1);
        beat("subn_exact",   1'b0, 8'h00, 24'h7FFFFF, 3'b000, RM_RNE, 32'h007FFFFF, 1'b0, 1'b0, 1'b0);
        beat("special_nan",  1'b0, EXP_MAX, 24'hC00000, 3'b100, RM_RUP, 32'h7FC00000, 1'b0, 1'b0, 1'b0);
        beat("rne_round_up", 1'b0, 8'h80, 24'h800000, 3'b110, RM_RNE, 32'h40000001, 1'b1, 1'b0, 1'b0);

        // Backpressure: out_ready low for cycles 3..5 while 4 exact beats stream in
        for (int k = 0; k < 4; k++) bp_exp[k] = 32'h40000000 + 32'(k);
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            @(negedge clk);
            in_valid  = (sent < 4);
            drive(1'b0, 8'h80, 24'h800000 + 24'(sent), 3'b000, RM_RTZ);
            out_ready = !(cyc >= 3 && cyc <= 5);
            #1;
            if (cyc >= 3 && cyc <= 5) begin
                check("bp in_ready stalled", 64'(in_ready),   64'(1'b0));
                check("bp held valid",       64'(out_valid),  64'(1'b1));
                check("bp held result",      64'(out_result), 64'(bp_exp[1]));
            end
            if (out_valid && out_ready) begin
                if (got < 4)
                    check("bp order", 64'(out_result), 64'(bp_exp[got]));
                else
                    check("bp extra beat", 64'(got), 64'(4));
                got++;
            end
            if (in_valid && in_ready) sent++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp beats out", 64'(got), 64'(4));

        // Reset with two beats in flight
        @(negedge clk);
        drive(1'b0, 8'h80, 24'hC00000, 3'b100, RM_RNE);
        in_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("inflight valid", 64'(out_valid), 64'(1'b1));
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("async rst valid", 64'(out_valid), 64'(1'b0));
        @(negedge clk);
        check("rst cnt cleared", 64'(inexact_cnt), 64'(2'd0));
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post rst no output", 64'(out_valid), 64'(1'b0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
